// File: rtl/jpeg2_byte_sink_if.sv
// Bus bundle between the bitstream source (jpeg_top / bench) and the byte
// sink: the word-level bitstream inputs and the byte-RAM write side.
interface jpeg2_byte_sink_if;
  logic [31:0] bits_in;
  logic        bits_rdy;
  logic [4:0]  eof_cnt;
  logic        eof_p;
  logic [7:0]  ram_byte;
  logic        ram_wren;
  logic [23:0] ram_wraddr;
  logic [23:0] frame_size;
  logic        frame_done;
  logic        overflow;
  logic        busy;

  // Source side: drives the bitstream words, observes the byte writes.
  modport master (
    output bits_in, bits_rdy, eof_cnt, eof_p,
    input  ram_byte, ram_wren, ram_wraddr, frame_size, frame_done, overflow, busy
  );

  // Sink side: consumes bitstream words, produces byte writes.
  modport slave (
    input  bits_in, bits_rdy, eof_cnt, eof_p,
    output ram_byte, ram_wren, ram_wraddr, frame_size, frame_done, overflow, busy
  );
endinterface

// File: rtl/jpeg2_byte_sink.sv
// Byte sink for the jpeg_top bitstream.
// Buffers 32-bit bitstream words (plus the final partial word of a frame) in
// a small FIFO and serialises them MSB-first as one byte per cycle onto a
// byte-write RAM port, optionally appending the FF D9 end-of-image marker.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | nothing loaded; pops the FIFO head when one is available
// S_SHIFT  | emitting bytes of the loaded word, MSB first
// S_EOI_FF | emitting the 0xFF half of the EOI marker
// S_EOI_D9 | emitting the 0xD9 half of the EOI marker
// S_DONE   | latching frame_size, pulsing frame_done, clearing address
module jpeg2_byte_sink #(
  parameter int FIFO_DEPTH = 8,
  parameter bit APPEND_EOI = 1'b1,
  parameter bit PAD_ONES   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  jpeg2_byte_sink_if.slave  sink_if
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_M1 = (AW+1)'(FIFO_DEPTH - 1);

  // Entry layout: {data[31:0], nbits[5:0], last}
  typedef logic [38:0] entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_EOI_FF,
    S_EOI_D9,
    S_DONE
  } state_t;

  // FIFO storage and pointers (one extra pointer bit separates full/empty)
  entry_t      mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] wr_ptr_d, rd_ptr_d;
  logic [AW:0] fill_c;
  logic        empty_c, full_c, room2_c;
  logic        push_word_c, push_part_c, drop_c, pop_c;
  logic [AW-1:0] wr_idx_c, wr_idx2_c;
  entry_t      word_entry_c, part_entry_c, head_c;
  logic        overflow_q;

  // Head-of-FIFO decode
  logic [31:0] h_data_c, h_mask_c, h_fill_c;
  logic [5:0]  h_nbits_c;
  logic        h_last_c;
  logic [2:0]  h_nbytes_c;
  state_t      end_state_c, load_state_c;

  // Serialiser registers
  state_t      state_q;
  logic [31:0] shift_q;
  logic [2:0]  cnt_q;
  logic        last_q;
  logic [23:0] addr_q;
  logic [7:0]  ram_byte_q;
  logic        ram_wren_q;
  logic [23:0] ram_wraddr_q;
  logic [23:0] frame_size_q;
  logic        frame_done_q;

  // Push/pop decisions; a simultaneous full+partial pair needs two free slots,
  // otherwise only the full word goes in and the partial one is dropped.
  always_comb begin
    fill_c       = wr_ptr_q - rd_ptr_q;
    empty_c      = (fill_c == '0);
    full_c       = (fill_c == DEPTH_V);
    room2_c      = (fill_c < DEPTH_M1);
    push_word_c  = sink_if.bits_rdy && !full_c;
    push_part_c  = sink_if.eof_p && (sink_if.bits_rdy ? room2_c : !full_c);
    drop_c       = (sink_if.bits_rdy && !push_word_c) || (sink_if.eof_p && !push_part_c);
    word_entry_c = {sink_if.bits_in, 6'd32, 1'b0};
    part_entry_c = {sink_if.bits_in, {1'b0, sink_if.eof_cnt}, 1'b1};
    wr_idx_c     = wr_ptr_q[AW-1:0];
    wr_idx2_c    = wr_idx_c + AW'(push_word_c);
    pop_c        = !empty_c &&
                   ((state_q == S_IDLE) ||
                    ((state_q == S_SHIFT) && (cnt_q == 3'd1) && !last_q));
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push_word_c) + (AW+1)'(push_part_c);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop_c);
  end

  // Decode the FIFO head: byte count, padded data and the state to load into.
  // Bits beyond nbits are forced to the pad value so the last partial byte
  // comes out padded without any per-byte masking later.
  always_comb begin
    head_c       = mem_q[rd_ptr_q[AW-1:0]];
    h_data_c     = head_c[38:7];
    h_nbits_c    = head_c[6:1];
    h_last_c     = head_c[0];
    h_nbytes_c   = 3'((h_nbits_c + 6'd7) >> 3);
    h_mask_c     = ~(32'hFFFF_FFFF >> h_nbits_c);
    h_fill_c     = PAD_ONES ? (h_data_c | ~h_mask_c) : (h_data_c & h_mask_c);
    end_state_c  = APPEND_EOI ? S_EOI_FF : S_DONE;
    if (h_nbytes_c != 3'd0) begin
      load_state_c = S_SHIFT;
    end else if (h_last_c) begin
      load_state_c = end_state_c;
    end else begin
      load_state_c = S_IDLE;
    end
  end

  // FIFO pointers and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_q | drop_c;
    end
  end

  // FIFO storage writes; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (push_word_c) mem_q[wr_idx_c]  <= word_entry_c;
    if (push_part_c) mem_q[wr_idx2_c] <= part_entry_c;
  end

  // Serialiser FSM with registered byte-write outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      addr_q       <= '0;
      ram_byte_q   <= '0;
      ram_wren_q   <= 1'b0;
      ram_wraddr_q <= '0;
      frame_size_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ram_wren_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty_c) begin
            shift_q <= h_fill_c;
            cnt_q   <= h_nbytes_c;
            last_q  <= h_last_c;
            state_q <= load_state_c;
          end
        end
        S_SHIFT: begin
          ram_byte_q   <= shift_q[31:24];
          ram_wren_q   <= 1'b1;
          ram_wraddr_q <= addr_q;
          addr_q       <= addr_q + 24'd1;
          shift_q      <= {shift_q[23:0], 8'h00};
          cnt_q        <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (last_q) begin
              state_q <= end_state_c;
            end else if (!empty_c) begin
              // back-to-back: next word loads while its predecessor's last byte goes out
              shift_q <= h_fill_c;
              cnt_q   <= h_nbytes_c;
              last_q  <= h_last_c;
              state_q <= load_state_c;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_EOI_FF: begin
          ram_byte_q   <= 8'hFF;
          ram_wren_q   <= 1'b1;
          ram_wraddr_q <= addr_q;
          addr_q       <= addr_q + 24'd1;
          state_q      <= S_EOI_D9;
        end
        S_EOI_D9: begin
          ram_byte_q   <= 8'hD9;
          ram_wren_q   <= 1'b1;
          ram_wraddr_q <= addr_q;
          addr_q       <= addr_q + 24'd1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          frame_size_q <= addr_q;
          frame_done_q <= 1'b1;
          addr_q       <= '0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sink_if.ram_byte   = ram_byte_q;
  assign sink_if.ram_wren   = ram_wren_q;
  assign sink_if.ram_wraddr = ram_wraddr_q;
  assign sink_if.frame_size = frame_size_q;
  assign sink_if.frame_done = frame_done_q;
  assign sink_if.overflow   = overflow_q;
  assign sink_if.busy       = !empty_c || (state_q != S_IDLE);

endmodule

// File: doc/jpeg2_byte_sink.md
Name: jpeg2_byte_sink

Overview:
- Receiver for the jpeg_top bitstream output: accepts 32-bit JPEG_bitstream words on data_ready, plus the partial final word flagged by eof_data_partial_ready and end_of_file_bitstream_count.
- Serialises them MSB-first into a byte-write RAM interface shaped like the JpegEnc output (ram_byte/ram_wren/ram_wraddr/frame_size).
- Lets the bench compare both encoders on one byte-stream checker.
- Sits between DUTV2 and the bench byte RAM/checker.

Parameters:
- FIFO_DEPTH, 8, word FIFO entries; power of two, minimum 2.
- APPEND_EOI, 1, when 1 append the 0xFF 0xD9 marker after the final byte of each frame.
- PAD_ONES, 1, when 1 pad unused low bits of the final partial byte with 1s; when 0 pad with 0s.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bits_in  in  32  JPEG_bitstream word; first bitstream bit is bit 31.
- bits_rdy  in  1  data_ready; full 32-bit word valid this cycle.
- eof_cnt  in  5  end_of_file_bitstream_count; number of valid MSB-aligned bits in the partial word.
- eof_p  in  1  eof_data_partial_ready; final partial word valid, ends the frame.
- ram_byte  out  8  output byte.
- ram_wren  out  1  byte write strobe; one byte per asserted cycle.
- ram_wraddr  out  24  byte address within the current frame.
- frame_size  out  24  byte count of the last completed frame.
- frame_done  out  1  one-cycle pulse when a frame completes.
- overflow  out  1  sticky; an input was dropped because the FIFO was full.
- busy  out  1  FIFO non-empty or serialiser not IDLE.

Behaviour:
- Reset (asynchronous): all outputs 0; FIFO empty; address counter 0; state IDLE.
- FIFO entry format: {data[31:0], nbits[5:0], last}.
- bits_rdy pushes {bits_in, 32, 0}.
- eof_p pushes {bits_in, eof_cnt, 1}.
  - eof_cnt = 0 is legal: zero data bytes, the frame still ends.
- If bits_rdy and eof_p are high in the same cycle, push the full word first, then the partial word.
  - This requires 2 free entries.
  - If only one entry is free, push the full word, drop the partial word, and set overflow.
- Push while full drops the input and sets overflow; overflow clears only on reset.
- Serialiser states:
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to SHIFT. Byte count = ceil(nbits/8).
  - SHIFT: emit data[31:24] with ram_wren=1, shift left 8, decrement the byte count.
    - When the count reaches 0 and last=0: pop the next entry in the same cycle if available (back-to-back bytes), otherwise go to IDLE.
    - When last=1: go to EOI_FF if APPEND_EOI, else DONE.
    - last=1 with byte count 0 goes directly to EOI_FF/DONE.
  - EOI_FF: emit 0xFF. Next state EOI_D9.
  - EOI_D9: emit 0xD9. Next state DONE.
  - DONE:
    - frame_size <= address counter (the total bytes written, including EOI bytes).
    - frame_done=1 for this one cycle.
    - Address counter <= 0.
    - Next state IDLE.
- Partial final byte: when nbits mod 8 ≠ 0, the low (8 − nbits mod 8) bits of the last byte are 1 if PAD_ONES, else 0.
- ram_wraddr is the address of the byte presented this cycle, counting 0,1,2,… from the start of the frame. It wraps modulo 2^24 without a flag.
- Latency: with IDLE and FIFO empty, a word sampled on bits_rdy at edge t gives its first byte on ram_wren in the cycle after edge t+2. Its 4 bytes then appear on consecutive cycles.
- Sustained throughput is 1 byte/cycle. Input faster than 1 word per 4 cycles fills the FIFO.
- frame_size holds its value until the next DONE.
- Bytes of the next frame may be pushed during DONE; they are serialised afterwards from address 0.
- Reset mid-frame discards the FIFO, shift register and partial frame. No frame_done is issued.

Test Plan:
- Single frame: words 0x12345678 and 0x9ABCDEF0, then eof_p with bits_in=0xA5000000, eof_cnt=12, APPEND_EOI=1, PAD_ONES=1 -> bytes 12 34 56 78 9A BC DE F0 A5 0F FF D9 at addresses 0..11, then frame_done with frame_size=12.
- Simultaneous bits_rdy and eof_p, bits_in=0xCAFEBABE, eof_cnt=0, APPEND_EOI=0 -> bytes CA FE BA BE (the partial word contributes nothing), then frame_done with frame_size=4.
- Latency/throughput: bits_rdy every 4th cycle for 16 words -> first ram_wren exactly 2 cycles after the first sample, 64 contiguous byte writes, overflow=0.
- Overflow: FIFO_DEPTH=2, bits_rdy on every cycle for 10 cycles -> overflow goes to 1 and stays 1. Bytes emitted are an in-order prefix of the input words with dropped words absent.
- Back-to-back frames: two frames of 1 full word each, no gap -> second frame addresses restart at 0. frame_size=6 after each frame with EOI.
- Reset mid-frame: assert rst during the 3rd byte of a word -> ram_wren=0 immediately (asynchronous), no frame_done. Next frame starts at address 0 with frame_size=0 until it completes.
